// File: rtl/booth2_mul_pkg.sv
// Shared definitions for the Booth multiplier carry-propagate stage:
// default widths, FSM state encoding and a full-adder helper.
package booth2_mul_pkg;

  localparam int DEF_DATA_WD  = 64;
  localparam int DEF_SLICE_WD = 16;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_ADD  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  // One full-adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    full_add = {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/booth2_mul_slice_adder.sv
// Combinational SLICE_WD-bit ripple-carry adder built from full-adder cells.
// The top time-shares one instance across all slices of the product.
module booth2_mul_slice_adder
  import booth2_mul_pkg::*;
#(
  parameter int SLICE_WD = DEF_SLICE_WD
) (
  input  logic [SLICE_WD-1:0] a_i,
  input  logic [SLICE_WD-1:0] b_i,
  input  logic                cin_i,
  output logic [SLICE_WD-1:0] sum_o,
  output logic                cout_o
);

  logic [1:0] fa_out;
  logic       ripple;

  // Ripple the carry from bit 0 upward through one full-adder cell per bit.
  always_comb begin
    sum_o  = '0;
    fa_out = '0;
    ripple = cin_i;
    for (int i = 0; i < SLICE_WD; i++) begin
      fa_out   = full_add(a_i[i], b_i[i], ripple);
      sum_o[i] = fa_out[0];
      ripple   = fa_out[1];
    end
    cout_o = ripple;
  end

endmodule

// File: rtl/booth2_mul_cpa.sv
// Final carry-propagate stage of the radix-4 Booth multiplier. Resolves the
// carry-save (sum, carry) pair into the product one slice per cycle so the
// full-width carry chain never sits on a single-cycle path.
module booth2_mul_cpa
  import booth2_mul_pkg::*;
#(
  parameter int DATA_WD  = DEF_DATA_WD,
  parameter int SLICE_WD = DEF_SLICE_WD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               val_i,
  output logic               rdy_o,
  input  logic [DATA_WD-1:0] sum_i,
  input  logic [DATA_WD-1:0] car_i,
  output logic               val_o,
  input  logic               rdy_i,
  output logic [DATA_WD-1:0] dat_o
);

  localparam int NUM_SLICE = DATA_WD / SLICE_WD;
  localparam int CNT_W     = (NUM_SLICE > 1) ? $clog2(NUM_SLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICE - 1);

  logic [ST_W-1:0]    state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               carry_q, carry_d;
  logic [DATA_WD-1:0] sum_q,   sum_d;
  logic [DATA_WD-1:0] car_q,   car_d;
  logic [DATA_WD-1:0] res_q,   res_d;
  logic [DATA_WD-1:0] dat_q,   dat_d;

  logic [SLICE_WD-1:0] sum_sl [NUM_SLICE];
  logic [SLICE_WD-1:0] car_sl [NUM_SLICE];
  logic [SLICE_WD-1:0] add_a;
  logic [SLICE_WD-1:0] add_b;
  logic [SLICE_WD-1:0] add_sum;
  logic                add_cout;
  logic [DATA_WD-1:0]  res_upd;

  // Split the latched operands into slices and merge the freshly added
  // slice into the partial result at the position selected by the counter.
  for (genvar g = 0; g < NUM_SLICE; g++) begin : g_slice
    assign sum_sl[g] = sum_q[g*SLICE_WD +: SLICE_WD];
    assign car_sl[g] = car_q[g*SLICE_WD +: SLICE_WD];
    assign res_upd[g*SLICE_WD +: SLICE_WD] =
      (cnt_q == CNT_W'(g)) ? add_sum : res_q[g*SLICE_WD +: SLICE_WD];
  end

  assign add_a = sum_sl[cnt_q];
  assign add_b = car_sl[cnt_q];

  booth2_mul_slice_adder #(
    .SLICE_WD (SLICE_WD)
  ) u_slice_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Next-state logic: accept in IDLE, one slice per cycle in ADD, hold the
  // product in DONE until downstream takes it. The final carry is dropped,
  // so the product wraps modulo 2^DATA_WD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    car_d   = car_q;
    res_d   = res_q;
    dat_d   = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (val_i) begin
          sum_d   = sum_i;
          car_d   = car_i;
          res_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        res_d   = res_upd;
        carry_d = add_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          dat_d   = res_upd;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rdy_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything and abandons any in-flight pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      car_q   <= '0;
      res_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      car_q   <= car_d;
      res_q   <= res_d;
      dat_q   <= dat_d;
    end
  end

  assign rdy_o = (state_q == ST_IDLE);
  assign val_o = (state_q == ST_DONE);
  assign dat_o = dat_q;

endmodule

// File: doc/booth2_mul_cpa.md
Name: booth2_mul_cpa

Overview:
Final carry-propagate stage of the signed radix-4 Booth multiplier. It takes the carry-save pair (sum vector, carry vector) produced by the 3:2 compressor tree and resolves it to the 64-bit two's-complement product. The add is done in SLICE_WD-bit slices, one slice per cycle, which keeps the carry chain off the critical path. The block uses a valid/ready handshake on both sides.

Parameters:
DATA_WD, 64, width of the carry-save vectors and of the product
SLICE_WD, 16, bits resolved per cycle; DATA_WD must be an integer multiple of SLICE_WD
NUM_SLICE, DATA_WD/SLICE_WD, derived, not overridable

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
val_i  input  1  upstream carry-save pair valid
rdy_o  output  1  block can accept a new pair
sum_i  input  DATA_WD  compressor-tree sum vector; bit k has weight 2^k
car_i  input  DATA_WD  compressor-tree carry vector, already left-aligned by upstream; bit k has weight 2^k
val_o  output  1  product valid
rdy_i  input  1  downstream ready
dat_o  output  DATA_WD  product = (sum_i + car_i) mod 2^DATA_WD

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset (rst=1 at an edge): state goes to IDLE, slice counter = 0, carry flag = 0, operand and result registers = 0. Outputs after reset: rdy_o=1, val_o=0, dat_o=0.
- FSM has three states: IDLE, ADD, DONE.
- IDLE:
  - rdy_o=1, val_o=0.
  - On val_i & rdy_o, latch sum_i and car_i, clear cnt and carry, then go to ADD.
- ADD:
  - rdy_o=0, val_o=0.
  - Each cycle, {carry, res[cnt*SLICE_WD +: SLICE_WD]} = sum_slice + car_slice + carry, then cnt = cnt+1.
  - When cnt == NUM_SLICE-1 is being processed, go to DONE.
- DONE:
  - val_o=1, rdy_o=0.
  - dat_o holds the full result and stays stable while rdy_i=0.
  - On val_o & rdy_i, go to IDLE.
- Latency: if a pair is accepted at edge T, val_o is high after edge T+NUM_SLICE (T+4 at default). Minimum initiation interval is NUM_SLICE+2 cycles.
- The carry out of the MSB slice is discarded: the result wraps modulo 2^DATA_WD. The signed 32x32 product always fits, so the wrap is correct by construction.
- val_i while rdy_o=0 is ignored. Upstream must hold val_i and its data until it sees rdy_o=1.
- dat_o is only meaningful while val_o=1. Between results, dat_o keeps the last completed product. Partial slices are never visible at dat_o: the partial result lives in an internal register, and the output register loads in the ADD→DONE transition.
- rst asserted in ADD or DONE aborts immediately: the in-flight result is lost and no val_o pulse follows.
- rst has priority over every handshake in the same cycle.
- Illegal or unused state encodings return to IDLE.

Decomposition:
- Shared package booth2_mul_pkg holds:
  - DATA_WD and SLICE_WD defaults;
  - the FSM state encoding ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2.
- One sub-module, booth2_mul_slice_adder: combinational SLICE_WD-bit ripple adder built from full-adder cells.
  - Inputs: a, b, cin. Outputs: sum, cout.
  - Instantiated once and time-shared across slices via cnt.

Test Plan:
- Carry across slice boundaries: sum_i=64'h0000_0000_FFFF_FFFF, car_i=64'h1 -> dat_o=64'h0000_0001_0000_0000. val_o rises exactly 4 cycles after acceptance.
- Signed product -7*3: sum_i=64'hFFFF_FFFF_FFFF_FFFF, car_i=64'hFFFF_FFFF_FFFF_FFEC -> dat_o=64'hFFFF_FFFF_FFFF_FFEB (-21).
- Wrap-around: sum_i=all ones, car_i=64'h1 -> dat_o=64'h0, with no extra flag or stall.
- Back-pressure:
  - Stimulus: complete a result with rdy_i=0 for 3 cycles while val_i=1 carries a new pair.
  - Required: dat_o and val_o stay stable, rdy_o stays 0, and the new pair is not taken until after the val_o&rdy_i handshake and the return to IDLE.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during the 2nd ADD cycle.
  - Required: next cycle rdy_o=1, val_o=0, dat_o=0, and no val_o pulse for the aborted pair. A following pair 64'h5 + 64'h3 yields 64'h8.
- Back-to-back throughput: two pairs presented continuously -> products emerge in order with an initiation interval of 6 cycles at default parameters (rdy_i tied high).
